// File: rtl/clear_ctrl_if.sv
// ============================================================================
// Module   : clear_ctrl_if
// Purpose  : Handshake/datapath bundle between clear_ctrl and its environment.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface clear_ctrl_if #(
  parameter int PIX_W = 15
);
  logic             start;
  logic             abort;
  logic [2:0]       colour_in;
  logic             xdone;
  logic             ydone;
  logic             initx;
  logic             inity;
  logic             loadx;
  logic             loady;
  logic             plot;
  logic [2:0]       colour_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic [PIX_W-1:0] pixel_count;

  modport master (
    input  start, abort, colour_in, xdone, ydone,
    output initx, inity, loadx, loady, plot, colour_out,
           busy, done, aborted, err, pixel_count
  );

  modport slave (
    output start, abort, colour_in, xdone, ydone,
    input  initx, inity, loadx, loady, plot, colour_out,
           busy, done, aborted, err, pixel_count
  );
endinterface

`default_nettype wire

// File: rtl/clear_ctrl.sv
// ============================================================================
// Module   : clear_ctrl
// Purpose  : Screen-clear sequencer; scans the x/y datapath row-major and plots.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clear_ctrl #(
  parameter int X_COUNT = 160,
  parameter int Y_COUNT = 120,
  parameter int PIX_W   = 15
) (
  input  wire logic     clock,
  input  wire logic     reset,
  clear_ctrl_if.master  bus
);

  localparam int COL_W = $clog2(X_COUNT + 1);

  generate
    if ((2 ** PIX_W) <= (X_COUNT * Y_COUNT)) begin : g_pix_w_check
      $error("clear_ctrl: PIX_W too narrow for X_COUNT*Y_COUNT");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_DRAW     = 3'd2,
    S_NEXT_ROW = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [2:0]       colour;
  logic [PIX_W-1:0] pix_cnt;
  logic             err_flag;

  logic active;
  logic take_abort;
  logic col_full;
  logic draw_plot;

  always_comb begin
    active     = (state == S_INIT) || (state == S_DRAW) || (state == S_NEXT_ROW);
    take_abort = active && bus.abort;
    col_full   = (col == COL_W'(X_COUNT));
    draw_plot  = (state == S_DRAW) && !bus.abort && !bus.ydone
                 && !bus.xdone && !col_full;
  end

  // Datapath strobes are decoded from state so they drop the instant reset hits.
  always_comb begin
    bus.initx   = !take_abort && ((state == S_INIT) || (state == S_NEXT_ROW));
    bus.inity   = !take_abort && (state == S_INIT);
    bus.loady   = !take_abort && ((state == S_INIT) || (state == S_NEXT_ROW));
    bus.loadx   = !take_abort && ((state == S_INIT) || (state == S_NEXT_ROW) || draw_plot);
    bus.plot    = draw_plot;
    bus.busy    = active;
    bus.done    = (state == S_DONE);
    bus.aborted = take_abort;
  end

  assign bus.colour_out  = colour;
  assign bus.pixel_count = pix_cnt;
  assign bus.err         = err_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      colour   <= '0;
      pix_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_INIT;
            colour   <= bus.colour_in;
            pix_cnt  <= '0;
            err_flag <= 1'b0;
          end
        end
        S_INIT: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            col   <= '0;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else if (bus.ydone) begin
            state <= S_DONE;
          end else if (!bus.xdone) begin
            if (!col_full) begin
              col <= col + 1'b1;
              if (pix_cnt != '1) begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end else begin
              // A full row plotted without xdone means the datapath is stuck.
              err_flag <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            state <= S_NEXT_ROW;
          end
        end
        S_NEXT_ROW: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            col   <= '0;
            state <= S_DRAW;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clear_ctrl.sv
// ============================================================================
// Module   : tb_clear_ctrl
// Purpose  : Directed/randomised bench for clear_ctrl with an x/y datapath model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clear_ctrl;

  localparam int X  = 6;
  localparam int Y  = 4;
  localparam int PW = 5;
  localparam int NPIX = X * Y;
  // Cycle index of DONE counting INIT as cycle 1: INIT, Y rows of
  // (X plots + xdone cycle + NEXT_ROW), the DRAW that sees ydone, then DONE.
  localparam int DONE_LAT = 1 + Y * (X + 2) + 1 + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  clear_ctrl_if #(.PIX_W(PW)) dif ();

  clear_ctrl #(.X_COUNT(X), .Y_COUNT(Y), .PIX_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clock = ~clock;

  // Datapath: scan registers that the controller must initialise itself.
  int x = 0;
  int y = 0;
  bit stuck = 1'b0;

  always @(posedge clock) begin
    if (dif.loadx) x <= dif.initx ? 0 : x + 1;
    if (dif.loady) y <= dif.inity ? 0 : y + 1;
  end

  assign dif.xdone = stuck ? 1'b0 : (x == X);
  assign dif.ydone = (y == Y);

  int checks = 0;
  int errors = 0;
  int px[$];
  int py[$];
  int done_cnt  = 0;
  int abort_cnt = 0;
  logic [2:0] exp_col = 3'd0;

  always @(negedge clock) begin
    if (!reset) begin
      if (dif.plot === 1'b1) begin
        px.push_back(x);
        py.push_back(y);
        checks++;
        assert (dif.xdone === 1'b0 && dif.ydone === 1'b0 && dif.busy === 1'b1
                && dif.colour_out === exp_col)
        else begin
          errors++;
          $error("FAIL plot_ctx: xdone=%b ydone=%b busy=%b colour=%0d required 0 0 1 %0d",
                 dif.xdone, dif.ydone, dif.busy, dif.colour_out, exp_col);
        end
      end
      if (dif.done === 1'b1) done_cnt++;
      if (dif.aborted === 1'b1) abort_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    px.delete();
    py.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  // Returns one cycle after the accepting edge, i.e. in INIT (cycle 1).
  task automatic do_start(input logic [2:0] c);
    dif.colour_in = c;
    exp_col       = c;
    dif.start     = 1'b1;
    tick();
    dif.start     = 1'b0;
  endtask

  task automatic run_to_done(input int from, output int cyc);
    cyc = from;
    while (dif.done !== 1'b1 && cyc < from + 200) begin
      tick();
      cyc++;
    end
  endtask

  // Plots expected in cycles 2..k-1 of an uninterrupted scan.
  function automatic int plots_before(input int k);
    int n = 0;
    for (int t = 2; t < k; t++) begin
      if (((t - 2) / (X + 2)) < Y && ((t - 2) % (X + 2)) < X) n++;
    end
    return n;
  endfunction

  task automatic check_scan(input string tag);
    int bad = 0;
    chk({tag, "_nplots"}, px.size(), NPIX);
    for (int i = 0; i < px.size() && i < NPIX; i++) begin
      if (px[i] != i % X || py[i] != i / X) bad++;
    end
    chk({tag, "_order_bad"}, bad, 0);
    if (px.size() > 0) begin
      chk({tag, "_last_x"}, px[px.size()-1], X - 1);
      chk({tag, "_last_y"}, py[py.size()-1], Y - 1);
    end
  endtask

  task automatic full_clear(input string tag, input logic [2:0] c);
    int cyc;
    clear_log();
    do_start(c);
    chk({tag, "_busy_init"}, dif.busy, 1);
    run_to_done(1, cyc);
    chk({tag, "_done_lat"}, cyc, DONE_LAT);
    chk({tag, "_pixcnt"}, dif.pixel_count, NPIX);
    chk({tag, "_colour"}, dif.colour_out, c);
    check_scan(tag);
    tick();
    chk({tag, "_idle_busy"}, dif.busy, 0);
    chk({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int ab;
    int rc;
    int exp_pc;
    int dq[$];
    logic [2:0] c;

    dif.start     = 1'b0;
    dif.abort     = 1'b0;
    dif.colour_in = 3'd0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {dif.plot, dif.busy, dif.done, dif.aborted, dif.err,
                        dif.loadx, dif.loady, dif.initx, dif.inity}, 0);
    chk("rst_colour", dif.colour_out, 0);
    chk("rst_pixcnt", dif.pixel_count, 0);
    @(negedge clock) reset = 1'b0;
    tick();

    // T1: basic clear with colour 5
    full_clear("t1", 3'd5);

    // T2: start pulses during the scan and during DONE are ignored
    c = 3'($urandom_range(1, 7));
    clear_log();
    do_start(c);
    repeat (8) tick();
    dif.start = 1'b1;
    dif.colour_in = ~c;
    tick();
    dif.start = 1'b0;
    chk("t2_busy_mid", dif.busy, 1);
    chk("t2_colour_mid", dif.colour_out, c);
    run_to_done(10, cyc);
    chk("t2_done_lat", cyc, DONE_LAT);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    chk("t2_no_restart", dif.busy, 0);
    tick();
    chk("t2_still_idle", dif.busy, 0);
    chk("t2_ndone", done_cnt, 1);
    chk("t2_colour_end", dif.colour_out, c);
    check_scan("t2");

    // T3: abort at a random point
    clear_log();
    ab = $urandom_range(3, DONE_LAT - 3);
    exp_pc = plots_before(ab);
    do_start(3'($urandom_range(1, 7)));
    repeat (ab - 1) tick();
    dif.abort = 1'b1;
    #1;
    chk("t3_aborted", dif.aborted, 1);
    chk("t3_no_plot", {dif.plot, dif.loadx, dif.loady}, 0);
    tick();
    dif.abort = 1'b0;
    chk("t3_idle", dif.busy, 0);
    chk("t3_pixcnt_hold", dif.pixel_count, exp_pc);
    chk("t3_nplots", px.size(), exp_pc);
    repeat (4) tick();
    chk("t3_no_more_plots", px.size(), exp_pc);
    chk("t3_ndone", done_cnt, 0);
    chk("t3_naborted", abort_cnt, 1);
    full_clear("t3b", 3'($urandom_range(1, 7)));

    // T4: asynchronous reset mid-scan
    clear_log();
    rc = $urandom_range(3, DONE_LAT - 3);
    do_start(3'($urandom_range(1, 7)));
    repeat (rc - 1) tick();
    #2 reset = 1'b1;
    #1;
    chk("t4_async_outputs", {dif.plot, dif.busy, dif.done, dif.aborted, dif.err,
                             dif.loadx, dif.loady, dif.initx, dif.inity}, 0);
    chk("t4_async_colour", dif.colour_out, 0);
    chk("t4_async_pixcnt", dif.pixel_count, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    tick();
    full_clear("t4b", 3'($urandom_range(1, 7)));

    // T5: xdone stuck low trips the watchdog after one row
    stuck = 1'b1;
    clear_log();
    do_start(3'($urandom_range(1, 7)));
    cyc = 1;
    while (dif.busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t5_idle_cycle", cyc, X + 3);
    chk("t5_err", dif.err, 1);
    chk("t5_nplots", px.size(), X);
    chk("t5_ndone", done_cnt, 0);
    repeat (3) tick();
    chk("t5_err_sticky", dif.err, 1);
    stuck = 1'b0;
    c = 3'($urandom_range(1, 7));
    do_start(c);
    chk("t5_err_cleared", dif.err, 0);
    clear_log();
    run_to_done(1, cyc);
    chk("t5b_done_lat", cyc, DONE_LAT);
    check_scan("t5b");
    tick();

    // T6: start held high restarts after one IDLE cycle
    clear_log();
    c = 3'($urandom_range(1, 7));
    dif.colour_in = c;
    exp_col = c;
    dif.start = 1'b1;
    tick();
    cyc = 1;
    while (dq.size() < 3 && cyc < 4 * DONE_LAT) begin
      tick();
      cyc++;
      if (dif.done === 1'b1) dq.push_back(cyc);
    end
    dif.start = 1'b0;
    chk("t6_ndone_seen", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("t6_first_done", dq[0], DONE_LAT);
      chk("t6_period_a", dq[1] - dq[0], DONE_LAT + 1);
      chk("t6_period_b", dq[2] - dq[1], DONE_LAT + 1);
    end
    chk("t6_total_plots", px.size(), 3 * NPIX);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
